// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue and issue-to-execute handshake bundle for the issue scoreboard.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer drives valid and payload; ready may depend on valid
// combinationally. The scoreboard never withdraws out_valid on its own while
// out_ready=0 except on flush or a new hazard-free decision (flush drops it).
// Payload is stable while valid=1 and ready=0.
interface issue_scoreboard_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic        in_use_rs1;
   logic        in_use_rs2;
   logic        in_reg_write;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic [4:0]  out_rd;
   logic        out_reg_write;

   // Environment side: decode producer and execute consumer.
   modport master (
      output in_valid, in_instr, in_pc, in_rs1, in_rs2, in_rd,
             in_use_rs1, in_use_rs2, in_reg_write, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_rd, out_reg_write
   );

   // Scoreboard side.
   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1, in_rs2, in_rd,
             in_use_rs1, in_use_rs2, in_reg_write, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_rd, out_reg_write
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage with a per-register busy scoreboard.
// Holds one decoded instruction and releases it to execute once none of its
// sources or its destination has an outstanding write. Writebacks clear busy
// bits in the same cycle they are checked, so a dependent instruction issues
// in the writeback cycle itself.
module issue_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   issue_scoreboard_if.slave    pipe,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_rd,
   input  logic                 flush,
   output logic [NREG-1:0]      busy_vec,
   output logic [5:0]           outstanding,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam logic [NREG-1:0] ONE = NREG'(1);

   // Hold register
   logic        hold_valid;
   logic [31:0] hold_instr;
   logic [63:0] hold_pc;
   logic [4:0]  hold_rs1;
   logic [4:0]  hold_rs2;
   logic [4:0]  hold_rd;
   logic        hold_use_rs1;
   logic        hold_use_rs2;
   logic        hold_reg_write;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_eff;
   logic [NREG-1:0] busy_next;
   logic [5:0]      busy_cnt_next;
   logic            hazard;
   logic            fire_in;
   logic            fire_out;
   logic            stall_inc;

   // Hazard detection against the busy bits after this cycle's writeback.
   always_comb begin
      clr_mask = '0;
      if (wb_valid && (wb_rd != 5'd0))
         clr_mask = ONE << wb_rd;
      busy_eff = busy & ~clr_mask;

      hazard = 1'b0;
      if (hold_valid) begin
         if (hold_use_rs1 && (hold_rs1 != 5'd0) && |(busy_eff & (ONE << hold_rs1)))
            hazard = 1'b1;
         if (hold_use_rs2 && (hold_rs2 != 5'd0) && |(busy_eff & (ONE << hold_rs2)))
            hazard = 1'b1;
         if (hold_reg_write && (hold_rd != 5'd0) && |(busy_eff & (ONE << hold_rd)))
            hazard = 1'b1;
      end

      pipe.out_valid = hold_valid & ~hazard & ~flush;
      fire_out       = pipe.out_valid & pipe.out_ready;
      pipe.in_ready  = ~flush & (~hold_valid | fire_out);
      fire_in        = pipe.in_valid & pipe.in_ready;
      stall_inc      = hazard & ~flush;
   end

   // Next busy vector: an issue marking rd wins over a same-cycle writeback.
   always_comb begin
      set_mask = '0;
      if (fire_out && hold_reg_write && (hold_rd != 5'd0))
         set_mask = ONE << hold_rd;
      busy_next = (busy_eff | set_mask) & ~ONE;

      busy_cnt_next = 6'd0;
      for (int i = 0; i < NREG; i++)
         busy_cnt_next = busy_cnt_next + {5'd0, busy_next[i]};
   end

   // Hold register: load on accept, empty on issue or flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_valid     <= 1'b0;
         hold_instr     <= '0;
         hold_pc        <= '0;
         hold_rs1       <= '0;
         hold_rs2       <= '0;
         hold_rd        <= '0;
         hold_use_rs1   <= 1'b0;
         hold_use_rs2   <= 1'b0;
         hold_reg_write <= 1'b0;
      end else if (fire_in) begin
         hold_valid     <= 1'b1;
         hold_instr     <= pipe.in_instr;
         hold_pc        <= pipe.in_pc;
         hold_rs1       <= pipe.in_rs1;
         hold_rs2       <= pipe.in_rs2;
         hold_rd        <= pipe.in_rd;
         hold_use_rs1   <= pipe.in_use_rs1;
         hold_use_rs2   <= pipe.in_use_rs2;
         hold_reg_write <= pipe.in_reg_write;
      end else if (fire_out || flush) begin
         hold_valid     <= 1'b0;
      end
   end

   // Busy bits and their popcount move together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy        <= '0;
         outstanding <= 6'd0;
      end else begin
         busy        <= busy_next;
         outstanding <= busy_cnt_next;
      end
   end

   // Saturating count of cycles lost to data hazards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cycles <= '0;
      else if (stall_inc && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

   assign pipe.out_instr     = hold_instr;
   assign pipe.out_pc        = hold_pc;
   assign pipe.out_rd        = hold_rd;
   assign pipe.out_reg_write = hold_reg_write;
   assign busy_vec           = busy;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Single-entry issue stage between decode and execute in the 64-bit in-order pipeline.
- Holds one decoded instruction and tracks a busy bit per architectural register for writes that are issued but not yet written back.
- Releases the held instruction to execute only when it has no RAW or WAW hazard and execute is ready.
- Reports outstanding-write count and a stall-cycle counter for performance statistics.

Parameters:
NREG, 32, number of architectural registers; busy vector width; x0 is never busy
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  scoreboard accepts the instruction this cycle
in_instr  input  32  raw instruction, carried through
in_pc  input  64  instruction PC, carried through
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_rd  input  5  destination register index
in_use_rs1  input  1  instruction reads rs1
in_use_rs2  input  1  instruction reads rs2
in_reg_write  input  1  instruction writes rd (ctl.reg_write)
out_valid  output  1  held instruction is issued to execute
out_ready  input  1  execute accepts
out_instr  output  32  held instruction
out_pc  output  64  held PC
out_rd  output  5  held rd
out_reg_write  output  1  held reg_write
wb_valid  input  1  writeback retires a register write
wb_rd  input  5  register being written back
flush  input  1  drop the held instruction (branch redirect)
busy_vec  output  NREG  current busy bits; bit 0 is always 0
outstanding  output  6  popcount of busy_vec
stall_cycles  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset=0, asynchronous): hold_valid=0, busy=0, stall_cycles=0. Outputs: out_valid=0, outstanding=0, in_ready=1, and out_instr/out_pc/out_rd/out_reg_write = 0.
- Writeback clear mask: clr = one-hot(wb_rd) when wb_valid and wb_rd≠0, else 0. busy_eff = busy & ~clr. Hazard checks use busy_eff, so writeback-to-issue latency is 0 cycles.
- hazard = hold_valid and any of:
  - use_rs1 and rs1≠0 and busy_eff[rs1]
  - use_rs2 and rs2≠0 and busy_eff[rs2]
  - reg_write and rd≠0 and busy_eff[rd] (WAW)
- out_valid = hold_valid & ~hazard & ~flush. fire_out = out_valid & out_ready.
- in_ready = ~flush & (~hold_valid | fire_out). fire_in = in_valid & in_ready. This is a pass-through slot with full throughput: one instruction per cycle when hazard-free.
- Hold register update:
  - fire_in: load all in_* fields and set hold_valid=1.
  - else fire_out: clear hold_valid.
  - flush: clear hold_valid and accept nothing.
  - out_* outputs reflect the hold register and are stable while out_valid=1 and out_ready=0.
- Busy update each cycle: busy_next = busy_eff | set, where set = one-hot(out_rd) if fire_out, out_reg_write and out_rd≠0.
  - Simultaneous writeback and issue to the same rd: set wins, so the bit stays 1.
  - Writeback to a non-busy register is ignored, with no error.
  - busy[0] is forced to 0.
- flush does not modify busy: instructions already issued still write back.
- outstanding = popcount(busy), registered with busy.
- stall_cycles increments by 1 each cycle that hold_valid & hazard & ~flush holds, and saturates at all-ones. Cycles stalled only by out_ready=0 are not counted.
- Reset mid-operation: the held instruction and all busy bits are discarded immediately; no out_valid is asserted until a new instruction is accepted.

Test Plan:
- Back-to-back independent: addi x1; addi x2,x3 with out_ready=1 and no writeback. Expect out_valid on consecutive cycles, in_ready held at 1, busy_vec=0x6, outstanding=2.
- RAW stall: issue addi x5; next instruction add x6,x5,x7. Expect out_valid=0 and stall_cycles incrementing each cycle. Assert wb_valid with wb_rd=5: add x6 issues in that same cycle, busy_vec=0x40.
- WAW plus simultaneous event: x8 busy, held addi x8, wb_rd=8 in the same cycle as issue. Expect fire_out and busy[8]=1 afterwards, outstanding unchanged.
- x0 handling: addi x0,x0,1 issues; busy_vec stays 0. A held instruction reading x0 never stalls, even after wb_rd=0 pulses.
- Backpressure and flush: hold valid with out_ready=0 for 3 cycles. Expect out_* stable, in_ready=0, stall_cycles unchanged. Assert flush: out_valid=0 that cycle, next cycle hold empty and in_ready=1, busy_vec unchanged.
- Async reset mid-stall: busy_vec=0x20, hold stalled, pull reset low between edges. Expect out_valid=0, busy_vec=0, outstanding=0, stall_cycles=0 immediately.
